// File: rtl/scope_capture.sv
// scope_capture: single-shot scope that arms, triggers on a rising level crossing,
// captures 2**DEPTH_LOG2 samples, then streams them out over valid/ready.
module scope_capture #(
    parameter int D_WIDTH    = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din,
    input  logic               arm,
    input  logic [D_WIDTH-1:0] trig_level,
    output logic [D_WIDTH-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               armed,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;
    localparam logic [DEPTH_LOG2-1:0] LAST = '1;
    state_t state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [D_WIDTH-1:0] prev_q, dout_q;
    logic [D_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic prev_valid_q, rd_done_q, dout_valid_q, dout_last_q, armed_q, busy_q;
    logic trig, we, load, xfer;
    assign trig = prev_valid_q && prev_q < trig_level && din >= trig_level;
    assign we   = en && ((state_q == ARMED && trig) || state_q == CAPTURE);
    // Refill the output register whenever it is empty or being drained, so a
    // held-high ready gives one transfer per cycle.
    assign load = state_q == READOUT && !rd_done_q && (!dout_valid_q || dout_ready);
    assign xfer = dout_valid_q && dout_ready;
    always_comb begin
        state_d = state_q == IDLE    ? (arm ? ARMED : IDLE) :
                  state_q == ARMED   ? (en && trig ? CAPTURE : ARMED) :
                  state_q == CAPTURE ? (en && wr_ptr_q == LAST ? READOUT : CAPTURE) :
                                       (xfer && dout_last_q ? IDLE : READOUT);
    end
    always_ff @(posedge clk) begin
        if (we) mem[state_q == ARMED ? '0 : wr_ptr_q] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            prev_valid_q <= 1'b0;
            rd_done_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= state_d == ARMED;
            busy_q  <= state_d != IDLE;
            if (state_q == IDLE && arm) prev_valid_q <= 1'b0;
            if (state_q == ARMED && en) begin
                prev_q       <= din;
                prev_valid_q <= 1'b1;
                if (trig) wr_ptr_q <= DEPTH_LOG2'(1);
            end
            if (state_q == CAPTURE && en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (wr_ptr_q == LAST) begin
                    rd_ptr_q  <= '0;
                    rd_done_q <= 1'b0;
                end
            end
            if (load) begin
                dout_q       <= mem[rd_ptr_q];
                dout_valid_q <= 1'b1;
                dout_last_q  <= rd_ptr_q == LAST;
                rd_ptr_q     <= rd_ptr_q + 1'b1;
                rd_done_q    <= rd_ptr_q == LAST;
            end else if (xfer) begin
                dout_valid_q <= 1'b0;
                dout_last_q  <= 1'b0;
            end
        end
    end
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign armed      = armed_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed vectors and hand-written capture/readout sequences
// for scope_capture at DEPTH_LOG2=4.
module tb_scope_capture;
    logic clk = 0, rst = 1, en = 0, arm = 0, dout_ready = 0;
    logic [7:0] din = 0, trig_level = 0, dout;
    logic dout_valid, dout_last, armed, busy;
    bit ramp = 0;
    int tests = 0, failed = 0;

    scope_capture #(.D_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm), .trig_level(trig_level),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .armed(armed), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, e, a;
        logic [7:0] d, lvl;
        logic x_armed, x_busy;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Ramp source: din advances only after a sample is consumed.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ramp && en) din = din + 8'd1;
    endtask

    task automatic pulse_arm();
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic wait_din(input logic [7:0] v);
        for (int c = 0; c < 3000 && din != v; c++) tick();
        chk("wait_din", din, v);
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic collect(input logic [7:0] base, input bit tog);
        int n = 0;
        bit stall = 0;
        logic [7:0] hd = 0;
        logic hl = 0;
        for (int c = 0; c < 400 && n < 16; c++) begin
            dout_ready = tog ? (c % 3 == 0) : 1'b1;
            arm = (n == 5);
            if (stall) begin
                chk("stall_valid", dout_valid, 1);
                chk("stall_data", dout, hd);
                chk("stall_last", dout_last, hl);
            end
            stall = dout_valid && !dout_ready;
            hd = dout;
            hl = dout_last;
            if (dout_valid && dout_ready) begin
                chk("data", dout, 8'(base + n));
                chk("last", dout_last, n == 15);
                n++;
            end else if (!tog && n > 0) chk("bubble", dout_valid, 1);
            tick();
        end
        arm = 0;
        dout_ready = 1;
        chk("xfer_count", n, 16);
        chk("end_valid", dout_valid, 0);
        chk("end_last", dout_last, 0);
        chk("end_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 0, 0, 8'd0,   8'd100, 0, 0};
        tbl[1] = '{0, 0, 1, 8'd200, 8'd100, 1, 1};
        tbl[2] = '{0, 1, 0, 8'd150, 8'd100, 1, 1};
        tbl[3] = '{0, 1, 0, 8'd200, 8'd100, 1, 1};
        tbl[4] = '{0, 1, 0, 8'd50,  8'd100, 1, 1};
        tbl[5] = '{0, 0, 0, 8'd150, 8'd100, 1, 1};
        tbl[6] = '{0, 1, 0, 8'd150, 8'd100, 0, 1};
        tbl[7] = '{0, 1, 0, 8'd151, 8'd100, 0, 1};

        tick();
        tick();
        rst = 0;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);

        // Ramp capture with ready held high, including first-valid latency.
        trig_level = 128;
        dout_ready = 1;
        din = 0;
        en = 1;
        ramp = 1;
        pulse_arm();
        chk("armed_after_arm", armed, 1);
        chk("busy_after_arm", busy, 1);
        wait_din(144);
        chk("valid_on_readout_entry", dout_valid, 0);
        tick();
        chk("first_valid", dout_valid, 1);
        chk("first_dout", dout, 128);
        collect(128, 0);

        // Same capture with a stalling consumer.
        din = 0;
        pulse_arm();
        wait_din(144);
        collect(128, 1);

        // Trigger qualification vectors.
        ramp = 0;
        foreach (tbl[i]) begin
            rst = tbl[i].r;
            en = tbl[i].e;
            arm = tbl[i].a;
            din = tbl[i].d;
            trig_level = tbl[i].lvl;
            tick();
            chk($sformatf("vec%0d_armed", i), armed, tbl[i].x_armed);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].x_busy);
        end
        rst = 0;
        arm = 0;
        din = 152;
        ramp = 1;
        en = 1;
        collect(150, 0);

        // A zero level can never be crossed from below.
        do_reset();
        trig_level = 0;
        din = 0;
        pulse_arm();
        for (int c = 0; c < 600; c++) begin
            tick();
            chk("lvl0_armed", armed, 1);
        end

        // Sparse en during capture.
        do_reset();
        trig_level = 128;
        din = 120;
        en = 1;
        pulse_arm();
        for (int c = 0; c < 2000 && din != 8'd144; c++) begin
            en = (c % 3 == 0);
            tick();
        end
        en = 0;
        chk("sparse_din", din, 144);
        collect(128, 0);

        // Reset mid-capture, then a fresh capture with extra arm pulses.
        do_reset();
        din = 120;
        en = 1;
        pulse_arm();
        wait_din(133);
        chk("mid_busy_pre", busy, 1);
        do_reset();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_armed", armed, 0);
        din = 100;
        pulse_arm();
        pulse_arm();
        chk("rearm_armed", armed, 1);
        wait_din(144);
        collect(128, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
